dmem_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of the single-port data memory. Shares the memory between the CPU load/store unit (requester 0) and the debug/DMA loader (requester 1) using round-robin arbitration, a valid/ready request handshake, and a one-cycle response pulse. Drives the memory's read/write/addr/in strobes and returns its registered read data. Out-of-range addresses are rejected without touching memory.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_MEM_AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; rr names the requester favoured on a tie.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr,
    output logic [1:0] grant
);

    logic [1:0] grant_s;

    // Pick the single valid requester, or the one favoured by rr when both are valid.
    always_comb begin
        grant_s = 2'b00;
        case (valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = rr ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    assign grant = grant_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing the single-port data memory between the LSU (0) and the loader (1).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MEM_AW = DEF_MEM_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_in,
    input  logic [DATA_W-1:0]   mem_out
);

    state_t              state_r;
    logic                rr_r;
    logic                owner_r;
    logic                we_r;
    logic                err_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                mem_read_r;
    logic                mem_write_r;
    logic [1:0]          rsp_valid_r;
    logic                rsp_err_r;
    logic                rd_en_r;

    logic                arb_en_s;
    logic [1:0]          grant_s;
    logic [1:0]          ready_s;
    logic                accept_s;
    logic                sel_owner_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_err_s;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .rr    (rr_r),
        .grant (grant_s)
    );

    // Arbitration is only open while no access is in flight (IDLE or the response cycle).
    always_comb begin
        arb_en_s = 1'b0;
        case (state_r)
            ST_IDLE:   arb_en_s = 1'b1;
            ST_RESP:   arb_en_s = 1'b1;
            ST_ACCESS: arb_en_s = 1'b0;
            default:   arb_en_s = 1'b0;
        endcase
    end

    assign ready_s     = arb_en_s ? grant_s : 2'b00;
    assign accept_s    = |(req_valid & ready_s);
    assign sel_owner_s = ready_s[1];

    // Route the winning requester's command fields and classify its address.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (sel_owner_s) begin
            sel_we_s    = req_we[1];
            sel_addr_s  = req_addr[2*ADDR_W-1:ADDR_W];
            sel_wdata_s = req_wdata[2*DATA_W-1:DATA_W];
        end else begin
            sel_we_s    = req_we[0];
            sel_addr_s  = req_addr[ADDR_W-1:0];
            sel_wdata_s = req_wdata[DATA_W-1:0];
        end
        sel_err_s = ((sel_addr_s >> MEM_AW) != {ADDR_W{1'b0}});
    end

    // Sequencer: accept -> one memory access cycle -> one response cycle (may overlap next accept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_r        <= 1'b0;
            owner_r     <= 1'b0;
            we_r        <= 1'b0;
            err_r       <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            rsp_valid_r <= 2'b00;
            rsp_err_r   <= 1'b0;
            rd_en_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    rsp_valid_r <= 2'b00;
                    rsp_err_r   <= 1'b0;
                    rd_en_r     <= 1'b0;
                    if (accept_s) begin
                        owner_r     <= sel_owner_s;
                        we_r        <= sel_we_s;
                        err_r       <= sel_err_s;
                        addr_r      <= sel_addr_s;
                        wdata_r     <= sel_wdata_s;
                        rr_r        <= ~sel_owner_s;
                        // Strobes are registered here so they are live for the whole ACCESS cycle.
                        mem_read_r  <= ~sel_we_s & ~sel_err_s;
                        mem_write_r <= sel_we_s & ~sel_err_s;
                        state_r     <= ST_ACCESS;
                    end else begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    rsp_valid_r <= owner_onehot(owner_r);
                    rsp_err_r   <= err_r;
                    rd_en_r     <= ~err_r & ~we_r;
                    state_r     <= ST_RESP;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    rsp_valid_r <= 2'b00;
                    rsp_err_r   <= 1'b0;
                    rd_en_r     <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = addr_r;
    assign mem_in    = wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    // Memory registers its read data on the edge closing ACCESS, so it is passed through, gated by a registered qualifier.
    assign rsp_rdata = rd_en_r ? mem_out : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory (mem[i] = i at start).
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic [31:0] mem_out;

    logic [31:0] mem [0:65535];
    int          wr_cnt;
    int          pass_cnt;
    int          total_cnt;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .mem_out   (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = i;
        mem_out = 32'h0;
        wr_cnt  = 0;
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[15:0]] <= mem_in;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_read) mem_out <= mem[mem_addr[15:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = 64'h0;
        req_wdata = 64'h0;

        // Reset state
        #3;
        chk("rst_ready", {30'h0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_in", mem_in, 32'h0);
        tick();
        rst_n = 1'b1;

        // Single read by requester 0
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h10;
        #1;
        chk("t1_ready", {30'h0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t1_mem_read", {31'h0, mem_read}, 32'h1);
        chk("t1_mem_write", {31'h0, mem_write}, 32'h0);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_ready_busy", {30'h0, req_ready}, 32'h0);
        tick();
        chk("t1_rsp_valid", {30'h0, rsp_valid}, 32'h1);
        chk("t1_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h10);
        chk("t1_strobe_off", {31'h0, mem_read}, 32'h0);
        tick();
        chk("t1_idle_rsp", {30'h0, rsp_valid}, 32'h0);

        // Requester 1 write, then requester 0 read-back accepted in the response cycle
        req_valid = 2'b10; req_we = 2'b10;
        req_addr[63:32] = 32'h20; req_wdata[63:32] = 32'hDEADBEEF;
        #1;
        chk("t2_ready1", {30'h0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        chk("t2_mem_write", {31'h0, mem_write}, 32'h1);
        chk("t2_mem_read", {31'h0, mem_read}, 32'h0);
        chk("t2_mem_addr", mem_addr, 32'h20);
        chk("t2_mem_in", mem_in, 32'hDEADBEEF);
        tick();
        chk("t2_wr_rsp", {30'h0, rsp_valid}, 32'h2);
        chk("t2_wr_rdata", rsp_rdata, 32'h0);
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h20;
        #1;
        chk("t2_ready0_in_resp", {30'h0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t2_rd_strobe", {30'h0, mem_read, mem_write}, 32'h2);
        tick();
        chk("t2_rd_rsp", {30'h0, rsp_valid}, 32'h1);
        chk("t2_rd_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t2_write_once", wr_cnt, 32'h1);
        tick();

        // Both requesters held valid from reset: grants alternate, one accept every two cycles
        pulse_reset();
        req_we = 2'b00;
        req_addr = {32'h200, 32'h100};
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t3_ready_%0d", i), {30'h0, req_ready}, (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("t3_addr_%0d", i), mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
            chk($sformatf("t3_rsp_%0d", i), {30'h0, rsp_valid}, (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("t3_rdata_%0d", i), rsp_rdata, (i % 2 == 0) ? 32'h100 : 32'h200);
        end
        req_valid = 2'b00;
        tick();

        // Out-of-range address: rejected with error, memory untouched
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h0001_0000;
        #1;
        chk("t4_ready", {30'h0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t4_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
        tick();
        chk("t4_rsp_valid", {30'h0, rsp_valid}, 32'h1);
        chk("t4_rsp_err", {31'h0, rsp_err}, 32'h1);
        chk("t4_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        chk("t4_err_clear", {31'h0, rsp_err}, 32'h0);

        // Reset during the write access: strobe drops, no commit, no response
        req_valid = 2'b01; req_we = 2'b01;
        req_addr[31:0] = 32'h5; req_wdata[31:0] = 32'h1234;
        tick();
        req_valid = 2'b00; req_we = 2'b00;
        chk("t5_write_live", {31'h0, mem_write}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_strobe_drop", {30'h0, mem_read, mem_write}, 32'h0);
        tick();
        chk("t5_no_commit", wr_cnt, 32'h1);
        rst_n = 1'b1;
        chk("t5_no_rsp_a", {30'h0, rsp_valid}, 32'h0);
        tick();
        chk("t5_no_rsp_b", {30'h0, rsp_valid}, 32'h0);
        req_valid = 2'b01; req_addr[31:0] = 32'h5;
        tick();
        req_valid = 2'b00;
        tick();
        chk("t5_readback", rsp_rdata, 32'h5);
        tick();

        // Requester 1 raises then withdraws a write while requester 0 is in flight
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h30;
        tick();
        req_valid = 2'b11; req_we = 2'b10;
        req_addr[63:32] = 32'h40; req_wdata[63:32] = 32'hAAAA;
        #1;
        chk("t6_busy_ready", {30'h0, req_ready}, 32'h0);
        req_valid = 2'b00; req_we = 2'b00;
        tick();
        chk("t6_rsp0", {30'h0, rsp_valid}, 32'h1);
        chk("t6_rdata0", rsp_rdata, 32'h30);
        tick();
        chk("t6_no_access", {30'h0, mem_read, mem_write}, 32'h0);
        chk("t6_no_rsp", {30'h0, rsp_valid}, 32'h0);
        chk("t6_no_write", wr_cnt, 32'h1);
        req_valid = 2'b11; req_addr = {32'h40, 32'h30};
        #1;
        chk("t6_rr_kept", {30'h0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        chk("t6_rsp1", {30'h0, rsp_valid}, 32'h2);
        chk("t6_rdata1", rsp_rdata, 32'h40);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
